// File: rtl/trivium_pkg.sv
// rtl/trivium_pkg.sv - shared constants, Trivium tap positions and UART state enum
package trivium_pkg;

    localparam int CLKS_PER_BIT = 10416;
    localparam int STATE_W      = 288;
    localparam int INIT_ROUNDS  = 1152;

    // Tap positions use Trivium's 1-based numbering s1..s288
    localparam int TAP_T1_A = 66;
    localparam int TAP_T1_B = 93;
    localparam int TAP_T2_A = 162;
    localparam int TAP_T2_B = 177;
    localparam int TAP_T3_A = 243;
    localparam int TAP_T3_B = 288;

    localparam int TAP_AND1_A = 91;
    localparam int TAP_AND1_B = 92;
    localparam int TAP_AND2_A = 175;
    localparam int TAP_AND2_B = 176;
    localparam int TAP_AND3_A = 286;
    localparam int TAP_AND3_B = 287;

    localparam int TAP_FB1 = 171;
    localparam int TAP_FB2 = 264;
    localparam int TAP_FB3 = 69;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    function automatic logic sbit(input logic [STATE_W-1:0] s, input int idx);
        return s[idx-1];
    endfunction

endpackage

// File: rtl/trivium_core.sv
// rtl/trivium_core.sv - 288-bit Trivium keystream generator with built-in warm-up
module trivium_core
    import trivium_pkg::*;
#(
    parameter logic [79:0] KEY         = 80'h0,
    parameter logic [79:0] IV          = 80'h0,
    parameter int          INIT_ROUNDS = trivium_pkg::INIT_ROUNDS
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic step,
    output logic z,
    output logic ready
);

    localparam int WARM_W = $clog2(INIT_ROUNDS + 1);

    logic [STATE_W-1:0] s;
    logic [STATE_W-1:0] s_next;
    logic [WARM_W-1:0]  warm_cnt;
    logic               t1, t2, t3;
    logic               f1, f2, f3;

    function automatic logic [STATE_W-1:0] init_state();
        logic [STATE_W-1:0] v;
        v          = '0;
        v[79:0]    = KEY;
        v[172:93]  = IV;
        v[287:285] = 3'b111;
        return v;
    endfunction

    // z is taken from the state before the update, as in the reference
    always_comb begin
        t1 = sbit(s, TAP_T1_A) ^ sbit(s, TAP_T1_B);
        t2 = sbit(s, TAP_T2_A) ^ sbit(s, TAP_T2_B);
        t3 = sbit(s, TAP_T3_A) ^ sbit(s, TAP_T3_B);
        z  = t1 ^ t2 ^ t3;
        f1 = t1 ^ (sbit(s, TAP_AND1_A) & sbit(s, TAP_AND1_B)) ^ sbit(s, TAP_FB1);
        f2 = t2 ^ (sbit(s, TAP_AND2_A) & sbit(s, TAP_AND2_B)) ^ sbit(s, TAP_FB2);
        f3 = t3 ^ (sbit(s, TAP_AND3_A) & sbit(s, TAP_AND3_B)) ^ sbit(s, TAP_FB3);
        s_next = {s[286:177], f2, s[175:93], f1, s[91:0], f3};
    end

    assign ready = (warm_cnt == WARM_W'(INIT_ROUNDS));

    always_ff @(posedge clk) begin
        if (rst) begin
            s        <= init_state();
            warm_cnt <= '0;
        end else if (ena) begin
            if (!ready) begin
                s        <= s_next;
                warm_cnt <= warm_cnt + 1'b1;
            end else if (step) begin
                s <= s_next;
            end
        end
    end

endmodule

// File: rtl/trivium_uart_cipher.sv
// rtl/trivium_uart_cipher.sv - 8N1 UART in, Trivium XOR, 8N1 UART out
module trivium_uart_cipher
    import trivium_pkg::*;
#(
    parameter int          CLKS_PER_BIT = trivium_pkg::CLKS_PER_BIT,
    parameter logic [79:0] KEY          = 80'h0,
    parameter logic [79:0] IV           = 80'h0,
    parameter int          INIT_ROUNDS  = trivium_pkg::INIT_ROUNDS
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic serial_in,
    output logic serial_out
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta, rx_sync, rx_prev;
    uart_state_t      rx_state, rx_state_d;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_cnt_clr, rx_take, rx_ok;

    logic             ci_active;
    logic [2:0]       ci_bit;
    logic [7:0]       ci_data, ci_next;
    logic             ci_step, ci_write;
    logic             ks_z, ks_ready;

    logic             buf_full;
    logic [7:0]       buf_data;

    uart_state_t      tx_state, tx_state_d;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_out, tx_out_d;
    logic             tx_load, tx_cnt_clr, tx_shift_en;

    trivium_core #(
        .KEY         (KEY),
        .IV          (IV),
        .INIT_ROUNDS (INIT_ROUNDS)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .step  (ci_step),
        .z     (ks_z),
        .ready (ks_ready)
    );

    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_clr = 1'b0;
        rx_take    = 1'b0;
        rx_ok      = 1'b0;
        case (rx_state)
            IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_d = START;
                    rx_cnt_clr = 1'b1;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch
                if (rx_cnt == HALF_END) begin
                    rx_cnt_clr = 1'b1;
                    rx_state_d = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_clr = 1'b1;
                    rx_take    = 1'b1;
                    if (rx_bit == 3'd7) rx_state_d = STOP;
                end
            end
            STOP: begin
                if (rx_cnt == BIT_END) begin
                    rx_state_d = IDLE;
                    rx_ok      = rx_sync;
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    assign ci_step  = ci_active && ks_ready;
    assign ci_next  = ci_data ^ ({7'b0, ks_z} << ci_bit);
    assign ci_write = ci_step && (ci_bit == 3'd7);

    always_comb begin
        tx_state_d  = tx_state;
        tx_out_d    = tx_out;
        tx_load     = 1'b0;
        tx_cnt_clr  = 1'b0;
        tx_shift_en = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_out_d = 1'b1;
                if (buf_full) begin
                    tx_load    = 1'b1;
                    tx_state_d = START;
                    tx_out_d   = 1'b0;
                end
            end
            START: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_clr = 1'b1;
                    tx_state_d = DATA;
                    tx_out_d   = tx_shift[0];
                end
            end
            DATA: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_clr = 1'b1;
                    if (tx_bit == 3'd7) begin
                        tx_state_d = STOP;
                        tx_out_d   = 1'b1;
                    end else begin
                        tx_shift_en = 1'b1;
                        tx_out_d    = tx_shift[1];
                    end
                end
            end
            STOP: begin
                // Back-to-back frames: the next start bit follows the stop bit directly
                if (tx_cnt == BIT_END) begin
                    tx_cnt_clr = 1'b1;
                    if (buf_full) begin
                        tx_load    = 1'b1;
                        tx_state_d = START;
                        tx_out_d   = 1'b0;
                    end else begin
                        tx_state_d = IDLE;
                    end
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= IDLE;
            rx_cnt    <= '0;
            rx_bit    <= 3'd0;
            rx_shift  <= 8'h00;
            ci_active <= 1'b0;
            ci_bit    <= 3'd0;
            ci_data   <= 8'h00;
            buf_full  <= 1'b0;
            buf_data  <= 8'h00;
            tx_state  <= IDLE;
            tx_cnt    <= '0;
            tx_bit    <= 3'd0;
            tx_shift  <= 8'h00;
            tx_out    <= 1'b1;
        end else if (ena) begin
            rx_meta  <= serial_in;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_d;
            rx_cnt   <= (rx_cnt_clr || rx_state == IDLE) ? '0 : rx_cnt + 1'b1;
            if (rx_state == IDLE) rx_bit <= 3'd0;
            else if (rx_take)     rx_bit <= rx_bit + 3'd1;
            if (rx_take) rx_shift <= {rx_sync, rx_shift[7:1]};

            if (rx_ok && !ci_active) begin
                ci_active <= 1'b1;
                ci_bit    <= 3'd0;
                ci_data   <= rx_shift;
            end else if (ci_step) begin
                ci_data <= ci_next;
                ci_bit  <= ci_bit + 3'd1;
                if (ci_bit == 3'd7) ci_active <= 1'b0;
            end

            // A ciphertext byte arriving at a full buffer is dropped
            if (tx_load) buf_full <= 1'b0;
            if (ci_write && !buf_full) begin
                buf_full <= 1'b1;
                buf_data <= ci_next;
            end

            tx_state <= tx_state_d;
            tx_out   <= tx_out_d;
            tx_cnt   <= (tx_cnt_clr || tx_load || tx_state == IDLE) ? '0 : tx_cnt + 1'b1;
            if (tx_load)          tx_shift <= buf_data;
            else if (tx_shift_en) tx_shift <= {1'b0, tx_shift[7:1]};
            if (tx_load)          tx_bit <= 3'd0;
            else if (tx_shift_en) tx_bit <= tx_bit + 3'd1;
        end
    end

    assign serial_out = tx_out;

endmodule

// File: tb/tb_trivium_uart_cipher.sv
// tb/tb_trivium_uart_cipher.sv - self-checking bench for trivium_uart_cipher
module tb_trivium_uart_cipher;

    localparam int          CPB    = 16;
    localparam int          ROUNDS = 1152;
    localparam logic [79:0] KEY_P  = 80'h0;
    localparam logic [79:0] IV_P   = 80'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b1;
    logic serial_in = 1'b1;
    logic serial_out;

    int checks = 0;
    int errors = 0;
    int frame_err = 0;
    logic [7:0] mon_q[$];
    logic [7:0] ks[0:15];

    always #5 clk = ~clk;

    trivium_uart_cipher #(
        .CLKS_PER_BIT (CPB),
        .KEY          (KEY_P),
        .IV           (IV_P),
        .INIT_ROUNDS  (ROUNDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .serial_in  (serial_in),
        .serial_out (serial_out)
    );

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference keystream straight from the cipher's textual definition on s[1..288]
    task automatic gen_ks();
        bit s[1:288];
        bit t1, t2, t3, z;
        logic [79:0] k;
        logic [79:0] v;
        int idx;
        k = KEY_P;
        v = IV_P;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            s[i]      = k[i-1];
            s[i + 93] = v[i-1];
        end
        s[286] = 1'b1;
        s[287] = 1'b1;
        s[288] = 1'b1;
        for (int r = 0; r < ROUNDS + 16 * 8; r++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            z  = t1 ^ t2 ^ t3;
            if (r >= ROUNDS) begin
                idx = r - ROUNDS;
                ks[idx / 8][idx % 8] = z;
            end
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int i = 288; i > 178; i--) s[i] = s[i-1];
            s[178] = t2;
            for (int i = 177; i > 94; i--) s[i] = s[i-1];
            s[94] = t1;
            for (int i = 93; i > 1; i--) s[i] = s[i-1];
            s[1] = t3;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
        serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        serial_in = stop_bit;
        repeat (CPB) @(negedge clk);
        serial_in = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic get_byte(input string tag, input logic [7:0] exp, output logic [7:0] got);
        int t;
        t = 0;
        while (mon_q.size() == 0 && t < 40 * CPB) begin
            @(negedge clk);
            t++;
        end
        if (mon_q.size() > 0) got = mon_q.pop_front();
        else                  got = 8'hxx;
        check8(tag, got, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (serial_out === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                if (serial_out === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        b[i] = serial_out;
                    end
                    repeat (CPB) @(negedge clk);
                    if (serial_out !== 1'b1) frame_err++;
                    mon_q.push_back(b);
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] msg[0:9];
        logic [7:0] cap[0:9];
        logic [7:0] got;
        logic [7:0] b;
        logic       low_seen;
        int         t;

        msg = '{8'hA5, 8'h3C, 8'h7F, 8'hC1, 8'h99, 8'h42, 8'hE7, 8'hB8, 8'h5D, 8'hF0};
        gen_ks();

        repeat (4) @(negedge clk);
        rst = 1'b0;
        check8("reset_out", {7'b0, serial_out}, 8'h01);

        low_seen = 1'b0;
        repeat (2000) begin
            @(negedge clk);
            if (serial_out !== 1'b1) low_seen = 1'b1;
        end
        check8("idle_line", {7'b0, low_seen}, 8'h00);
        check8("idle_frames", 8'(mon_q.size()), 8'h00);

        send_byte(8'h00, 1'b1, 2 * CPB);
        get_byte("first_ks", 8'hFB, got);
        send_byte(8'h00, 1'b1, 2 * CPB);
        get_byte("second_ks", 8'hE0, got);

        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check8("glitch_frames", 8'(mon_q.size()), 8'h00);
        b = 8'($urandom);
        send_byte(b, 1'b1, 2 * CPB);
        get_byte("after_glitch", b ^ ks[2], got);

        send_byte(8'($urandom), 1'b0, 2 * CPB);
        repeat (12 * CPB) @(negedge clk);
        check8("framing_drop", 8'(mon_q.size()), 8'h00);
        b = 8'($urandom);
        send_byte(b, 1'b1, 2 * CPB);
        get_byte("after_framing", b ^ ks[3], got);

        do_reset();
        repeat (ROUNDS + 150) @(negedge clk);
        for (int i = 0; i < 10; i++) send_byte(msg[i], 1'b1, 2 * CPB);
        for (int i = 0; i < 10; i++) begin
            get_byte($sformatf("enc%0d", i), msg[i] ^ ks[i], got);
            cap[i] = got;
        end

        do_reset();
        repeat (ROUNDS + 150) @(negedge clk);
        for (int i = 0; i < 10; i++) send_byte(cap[i], 1'b1, 2 * CPB);
        for (int i = 0; i < 10; i++) get_byte($sformatf("dec%0d", i), msg[i], got);

        // Byte chosen so its ciphertext is 0x00: the line stays low through the data bits
        send_byte(ks[10], 1'b1, 0);
        t = 0;
        while (serial_out !== 1'b0 && t < 4 * CPB) begin
            @(negedge clk);
            t++;
        end
        repeat (3 * CPB) @(negedge clk);
        check8("mid_tx_low", {7'b0, serial_out}, 8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check8("rst_mid_tx", {7'b0, serial_out}, 8'h01);
        @(negedge clk);
        rst = 1'b0;
        repeat (ROUNDS + 150) @(negedge clk);
        mon_q.delete();
        b = 8'($urandom);
        send_byte(b, 1'b1, 2 * CPB);
        get_byte("post_rst_ks", b ^ ks[0], got);

        check8("frame_errors", 8'(frame_err), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
